// File: rtl/assert_event_sched_if.sv
// Report handshake between the checker instances and the scheduler.
// Checkers drive req/sev; the scheduler answers with a one-hot ack and the granted index.
interface assert_event_sched_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] sev;
  logic [NREQ-1:0] ack;
  logic [GW-1:0]   grant_id;

  modport master (output req, output sev, input ack, input grant_id);
  modport slave  (input req, input sev, output ack, output grant_id);
endinterface

// File: rtl/assert_event_sched.sv
// Serialises error/warning reports from NREQ checkers into saturating counters, gates counting
// behind a post-reset holdoff window and raises a sticky finish request per the exit policy.
module assert_event_sched #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned CW           = 32,
  parameter int unsigned HOLDOFF      = 8,
  parameter int unsigned ERR_LIMIT    = 1,
  parameter bit          EXIT_ON_WARN = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  assert_event_sched_if.slave  bus,
  output logic                 message_on,
  output logic [CW-1:0]        errors,
  output logic [CW-1:0]        warnings,
  output logic                 warn_notice,
  output logic                 finish_req
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = $clog2(HOLDOFF + 1) + 1;

  typedef enum logic [1:0] {StHold, StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q;
  logic [HW-1:0]   cnt_q;
  logic [CW-1:0]   errors_q, errors_d;
  logic [CW-1:0]   warnings_q, warnings_d;
  logic            warn_notice_q;

  logic            gnt_found;
  logic [GW-1:0]   gnt_idx;
  logic [GW-1:0]   cand;
  logic            grant;
  logic            gnt_sev;
  logic            count_en;
  logic            fin_cond;

  // Rotating priority search starting at the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = GW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found && bus.req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A grant offered while reset is high would be dropped anyway, so it is never shown.
  assign grant        = gnt_found && !reset;
  assign gnt_sev      = bus.sev[gnt_idx];
  assign bus.ack      = grant ? (NREQ'(1) << gnt_idx) : '0;
  assign bus.grant_id = grant ? gnt_idx : '0;
  assign count_en     = grant && (state_q != StHold);

  always_comb begin
    errors_d   = errors_q;
    warnings_d = warnings_q;
    if (count_en) begin
      if (gnt_sev) begin
        if (errors_q != '1) errors_d = errors_q + CW'(1);
      end else if (warnings_q != '1) begin
        warnings_d = warnings_q + CW'(1);
      end
    end
  end

  assign fin_cond = ((ERR_LIMIT != 0) && (errors_d >= CW'(ERR_LIMIT))) ||
                    (EXIT_ON_WARN && (warnings_d != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      cnt_q         <= '0;
      errors_q      <= '0;
      warnings_q    <= '0;
      warn_notice_q <= 1'b0;
    end else begin
      if (grant) ptr_q <= (gnt_idx == GW'(NREQ - 1)) ? '0 : gnt_idx + GW'(1);
      if (state_q == StHold) cnt_q <= cnt_q + HW'(1);
      errors_q      <= errors_d;
      warnings_q    <= warnings_d;
      // Notices stop once a finish has already been requested.
      warn_notice_q <= count_en && !gnt_sev && (state_q != StHalt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StHold;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold: if (cnt_q + HW'(1) >= HW'(HOLDOFF)) state_d = StRun;
      StRun:  if (fin_cond) state_d = StHalt;
      StHalt: state_d = StHalt;
      default: state_d = StHold;
    endcase
  end

  always_comb begin
    message_on = (state_q != StHold);
    finish_req = (state_q == StHalt);
  end

  assign errors      = errors_q;
  assign warnings    = warnings_q;
  assign warn_notice = warn_notice_q;

endmodule

// File: tb/tb_assert_event_sched.sv
// Randomised scoreboard bench for assert_event_sched: two configurations share one stimulus
// stream; a reference model queues expected outputs and a monitor compares each cycle.
module tb_assert_event_sched;
  localparam int unsigned N = 4;

  localparam int HOLD_A = 8;
  localparam int MAX_A  = 15;
  localparam int ELIM_A = 1;
  localparam bit EOW_A  = 1'b0;

  localparam int HOLD_B = 0;
  localparam int MAX_B  = 255;
  localparam int ELIM_B = 0;
  localparam bit EOW_B  = 1'b1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_v = '0;
  logic [N-1:0] sev_v = '0;

  always #5 clk = ~clk;

  assert_event_sched_if #(.NREQ(N)) bus_a ();
  assert_event_sched_if #(.NREQ(N)) bus_b ();
  assign bus_a.req = req_v;
  assign bus_a.sev = sev_v;
  assign bus_b.req = req_v;
  assign bus_b.sev = sev_v;

  logic       msg_a, wn_a, fin_a, msg_b, wn_b, fin_b;
  logic [3:0] err_a, warn_a;
  logic [7:0] err_b, warn_b;

  assert_event_sched #(
    .NREQ(N), .CW(4), .HOLDOFF(HOLD_A), .ERR_LIMIT(ELIM_A), .EXIT_ON_WARN(EOW_A)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .message_on(msg_a), .errors(err_a),
    .warnings(warn_a), .warn_notice(wn_a), .finish_req(fin_a)
  );

  assert_event_sched #(
    .NREQ(N), .CW(8), .HOLDOFF(HOLD_B), .ERR_LIMIT(ELIM_B), .EXIT_ON_WARN(EOW_B)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .message_on(msg_b), .errors(err_b),
    .warnings(warn_b), .warn_notice(wn_b), .finish_req(fin_b)
  );

  typedef struct {
    logic [N-1:0] ack;
    logic [1:0]   gid;
    logic         msg;
    int           err;
    int           warn;
    logic         wn;
    logic         fin;
  } exp_t;

  typedef struct {
    int since;
    int err;
    int warn;
    bit wn;
    bit fin;
  } mdl_t;

  exp_t q_a[$];
  exp_t q_b[$];
  mdl_t m_a = '{0, 0, 0, 1'b0, 1'b0};
  mdl_t m_b = '{0, 0, 0, 1'b0, 1'b0};
  int ptr = 0;
  logic [N-1:0] last_ack = '0;
  int errs = 0;
  int checks = 0;

  function automatic exp_t mk_exp(input mdl_t m, input int hold, input logic [N-1:0] a,
                                  input int g);
    exp_t e;
    e.ack  = a;
    e.gid  = (g >= 0) ? 2'(g) : 2'd0;
    e.msg  = m.since >= ((hold == 0) ? 1 : hold);
    e.err  = m.err;
    e.warn = m.warn;
    e.wn   = m.wn;
    e.fin  = m.fin;
    return e;
  endfunction

  // Behavioural rules: count only while messages are on, saturate, latch finish.
  task automatic step(inout mdl_t m, input bit rst, input int g, input bit s, input int hold,
                      input int maxv, input int elim, input bit eow);
    bit counted;
    if (rst) begin
      m = '{0, 0, 0, 1'b0, 1'b0};
    end else begin
      counted = (g >= 0) && (m.since >= ((hold == 0) ? 1 : hold));
      m.wn = 1'b0;
      if (counted) begin
        if (s) begin
          m.err = (m.err < maxv) ? m.err + 1 : maxv;
        end else begin
          m.warn = (m.warn < maxv) ? m.warn + 1 : maxv;
          m.wn = !m.fin;
        end
      end
      m.fin = m.fin || ((elim != 0) && (m.err >= elim)) || (eow && (m.warn != 0));
      if (m.since < 1000) m.since++;
    end
  endtask

  task automatic eval_push();
    int g;
    int i;
    logic [N-1:0] a;
    g = -1;
    a = '0;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        i = (ptr + k) % N;
        if (g < 0 && req_v[i]) g = i;
      end
    end
    if (g >= 0) a[g] = 1'b1;
    q_a.push_back(mk_exp(m_a, HOLD_A, a, g));
    q_b.push_back(mk_exp(m_b, HOLD_B, a, g));
    step(m_a, reset, g, (g >= 0) ? sev_v[g] : 1'b0, HOLD_A, MAX_A, ELIM_A, EOW_A);
    step(m_b, reset, g, (g >= 0) ? sev_v[g] : 1'b0, HOLD_B, MAX_B, ELIM_B, EOW_B);
    if (reset) ptr = 0;
    else if (g >= 0) ptr = (g + 1) % N;
    last_ack = a;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] sv);
    reset = r;
    req_v = rq;
    sev_v = sv;
    eval_push();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycles(input int n);
    logic [N-1:0] rq, sv;
    for (int c = 0; c < n; c++) begin
      rq = req_v & ~last_ack;
      sv = sev_v;
      for (int i = 0; i < N; i++) begin
        if (rq[i] && $urandom_range(0, 9) == 0) begin
          rq[i] = 1'b0;
        end else if (!req_v[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
          sv[i] = 1'($urandom_range(0, 1));
        end
      end
      drive(1'b0, rq, sv);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e, input logic [N-1:0] ack,
                         input logic [1:0] gid, input logic msg, input logic [31:0] er,
                         input logic [31:0] wr, input logic wn, input logic fin);
    chk({tag, ".ack"}, 32'(ack), 32'(e.ack));
    chk({tag, ".grant_id"}, 32'(gid), 32'(e.gid));
    chk({tag, ".message_on"}, 32'(msg), 32'(e.msg));
    chk({tag, ".errors"}, er, e.err);
    chk({tag, ".warnings"}, wr, e.warn);
    chk({tag, ".warn_notice"}, 32'(wn), 32'(e.wn));
    chk({tag, ".finish_req"}, 32'(fin), 32'(e.fin));
  endtask

  exp_t e_a, e_b;
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      e_a = q_a.pop_front();
      chk_all("a", e_a, bus_a.ack, bus_a.grant_id, msg_a, 32'(err_a), 32'(warn_a), wn_a, fin_a);
    end
    if (q_b.size() > 0) begin
      e_b = q_b.pop_front();
      chk_all("b", e_b, bus_b.ack, bus_b.grant_id, msg_b, 32'(err_b), 32'(warn_b), wn_b, fin_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    drive(1'b1, '0, '0);
    drive(1'b1, '0, '0);
    // Holdoff window: error at cycle 3 is acked but not counted by the HOLDOFF=8 instance.
    for (int c = 0; c < 10; c++) begin
      if (c == 3)      drive(1'b0, 4'b0010, 4'b0010);
      else if (c == 5) drive(1'b0, 4'b1000, 4'b0000);
      else             drive(1'b0, 4'b0000, 4'b0000);
    end
    // Round-robin fairness with all four warnings held.
    for (int c = 0; c < 8; c++) drive(1'b0, 4'b1111, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0100, 4'b0100);
    drive(1'b0, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0001, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    rand_cycles(80);
    // Saturation of the 4-bit warning counter.
    drive(1'b0, 4'b0000, 4'b0000);
    for (int c = 0; c < 20; c++) drive(1'b0, 4'b1111, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    rand_cycles(10);
    // Reset mid-operation with a live request.
    drive(1'b1, 4'b1000, 4'b1000);
    for (int c = 0; c < 3; c++) drive(1'b0, 4'b0000, 4'b0000);
    rand_cycles(30);
    for (int c = 0; c < 3; c++) drive(1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    #1;
    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_b", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/assert_event_sched.md
Name: assert_event_sched

Overview:
- Central scheduler for the simulation error/warning bookkeeping resource used by vpassert-generated checkers running with --nostop.
- Accepts error/warning reports from NREQ independent checker instances and serialises them through a round-robin arbiter into one error counter and one warning counter.
- Sequences the message-enable window after reset, so that checks stay silent until reset has settled.
- Raises a sticky finish request when the configured exit policy is met.

Parameters:
- NREQ, 4, number of reporting checkers (1..16).
- CW, 32, width of the error and warning counters.
- HOLDOFF, 8, cycles after reset deassertion before message_on rises (0 means message_on rises on the first cycle out of reset).
- ERR_LIMIT, 1, error count that triggers finish_req (0 disables error-triggered finish).
- EXIT_ON_WARN, 0, when 1 any counted warning also triggers finish_req.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- req  in  NREQ  Per-checker report request; held high until acked.
- sev  in  NREQ  Per-checker severity, valid while req is high: 1 = error, 0 = warning.
- ack  out  NREQ  One-hot grant; at most one bit high per cycle.
- grant_id  out  clog2(NREQ) max 1  Index of the acked requester; 0 when ack is 0.
- message_on  out  1  High when reports are being counted.
- errors  out  CW  Saturating count of counted errors.
- warnings  out  CW  Saturating count of counted warnings.
- warn_notice  out  1  One-cycle pulse for each counted warning while finish_req is low.
- finish_req  out  1  Sticky request to end simulation.

Behaviour:
- Reset values:
  - ack=0, grant_id=0, message_on=0, errors=0, warnings=0, warn_notice=0, finish_req=0.
  - Round-robin pointer=0; holdoff counter=0; state=HOLD.
  - Reset asserted mid-operation clears everything on that edge, including a sticky finish_req; a pending ack is dropped.
- FSM states: HOLD, RUN, HALT.
  - HOLD: holdoff counter increments each cycle. When it reaches HOLDOFF, go to RUN, and message_on goes to 1 on the same edge.
  - RUN: message_on=1. When the finish condition becomes true, go to HALT on the same edge that finish_req rises.
  - HALT: message_on stays 1, finish_req stays 1, and counting continues. Exit from HALT is by reset only.
- Arbitration:
  - Combinational in the same cycle as req.
  - Search starts at the pointer index and proceeds upward with wrap-around; the first requester found with req=1 gets ack=1.
  - On a grant, the pointer becomes (granted index + 1) mod NREQ on the next edge. With no grant, the pointer holds.
  - Arbitration runs in every state, including HOLD. Reports granted in HOLD are acked but not counted.
- Counting, one edge after ack:
  - errors increments if the granted sev=1; warnings increments if the granted sev=0.
  - Only one count per cycle (maximum throughput is one report per cycle).
  - Both counters saturate at all-ones with no wrap.
- warn_notice: registered. High for exactly one cycle, on the same edge the warnings counter increments, and only if finish_req was 0 before that edge.
- Finish condition, evaluated on the post-increment values:
  - (ERR_LIMIT != 0 and errors >= ERR_LIMIT), or
  - (EXIT_ON_WARN = 1 and warnings != 0).
  - finish_req rises on the same edge as the counter update that satisfies the condition.
- A requester that drops req without an ack loses its report; this is legal.
- A requester must hold sev stable while req is high.
- Simultaneous requests: exactly one is granted per cycle. With NREQ requesters held continuously, each is granted once every NREQ cycles.

Test Plan:
- Holdoff window: NREQ=4, HOLDOFF=8; release reset, req[1]=1 with sev=1 at cycle 3 after reset → ack[1] at cycle 3; errors stays 0; message_on rises at cycle 8; finish_req stays 0.
- Round-robin fairness: after message_on=1, hold req=4'b1111 with all sev=0 for 8 cycles → ack order 0,1,2,3,0,1,2,3; warnings=8; warn_notice high on 8 consecutive cycles.
- Error finish: ERR_LIMIT=1; single error from req[2] → errors=1 and finish_req=1 on the edge after ack; state HALT; a further warning gives warnings=1 and warn_notice=0.
- EXIT_ON_WARN=1, ERR_LIMIT=0: one warning → finish_req=1 one edge after ack; then 3 errors → errors=3, finish_req stays 1.
- Saturation: CW=4; 17 warnings → warnings=15 and holds, no wrap; warn_notice still pulses per counted report.
- Reset mid-operation: assert reset for 1 cycle while req[3]=1, finish_req=1, errors=5 → next cycle all outputs equal reset values, pointer=0, state=HOLD.
